// File: rtl/reverse_base_stack_if.sv
// Avalon-ST style stream of 8-bit bases with packet framing.
// The source drives data/valid/framing; the sink drives ready.
interface reverse_base_stack_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       startofpacket;
    logic       endofpacket;

    modport master (
        output data,
        output valid,
        output startofpacket,
        output endofpacket,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  startofpacket,
        input  endofpacket,
        output ready
    );
endinterface

// File: rtl/reverse_base_stack.sv
// Packet reverser: stacks the bases of one packet, then replays them last-in first-out.
// Packets longer than DEPTH are truncated to their first DEPTH bases; the rest is dropped.
module reverse_base_stack #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                      csi_clock,
    input  logic                      rsi_reset_n,
    reverse_base_stack_if.slave       asi_in,
    reverse_base_stack_if.master      aso_out,
    output logic                      coe_overflow,
    output logic [ADDR_W:0]           coe_level
);

    typedef enum logic [1:0] {
        StFill,
        StDrain,
        StDiscard
    } state_e;

    localparam logic [ADDR_W:0] LevelOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [ADDR_W:0] sp_q, sp_d;
    logic            pend_q, pend_d;
    logic            first_q, first_d;
    logic            ovf_q, ovf_d;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W:0]   sp_inc;
    logic [ADDR_W:0]   sp_dec;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_fire;
    logic              out_fire;
    logic              push;
    logic              unused_in_sop;

    assign unused_in_sop = asi_in.startofpacket;

    assign sp_inc  = sp_q + LevelOne;
    assign sp_dec  = sp_q - LevelOne;
    assign wr_addr = sp_q[ADDR_W-1:0];
    assign rd_addr = sp_dec[ADDR_W-1:0];

    // Ready is gated by reset so the source sees no acceptance while reset is held.
    assign asi_in.ready  = rsi_reset_n && (state_q != StDrain);
    assign aso_out.valid = (state_q == StDrain);
    assign aso_out.data  = aso_out.valid ? mem[rd_addr] : 8'h00;
    assign aso_out.startofpacket = aso_out.valid && first_q;
    assign aso_out.endofpacket   = aso_out.valid && (sp_q == LevelOne);

    assign coe_overflow = ovf_q;
    assign coe_level    = sp_q;

    assign in_fire  = asi_in.valid && asi_in.ready;
    assign out_fire = aso_out.valid && aso_out.ready;

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        pend_d  = pend_q;
        first_d = first_q;
        ovf_d   = 1'b0;
        push    = 1'b0;

        unique case (state_q)
            StFill: begin
                if (in_fire) begin
                    push = 1'b1;
                    sp_d = sp_inc;
                    if (asi_in.endofpacket) begin
                        state_d = StDrain;
                        first_d = 1'b1;
                    end else if (sp_inc == LevelFull) begin
                        // Stack full mid-packet: replay what we have, drop the tail later.
                        ovf_d   = 1'b1;
                        pend_d  = 1'b1;
                        state_d = StDrain;
                        first_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_fire) begin
                    sp_d    = sp_dec;
                    first_d = 1'b0;
                    if (sp_q == LevelOne) begin
                        state_d = pend_q ? StDiscard : StFill;
                    end
                end
            end
            StDiscard: begin
                if (in_fire && asi_in.endofpacket) begin
                    pend_d  = 1'b0;
                    state_d = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge csi_clock or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= StFill;
            sp_q    <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage carries no reset; sp alone defines which entries are live.
    always_ff @(posedge csi_clock) begin
        if (push) begin
            mem[wr_addr] <= asi_in.data;
        end
    end

`ifndef SYNTHESIS
    a_level_bound : assert property (@(posedge csi_clock) disable iff (!rsi_reset_n)
        sp_q <= LevelFull);

    a_out_hold : assert property (@(posedge csi_clock) disable iff (!rsi_reset_n)
        (aso_out.valid && !aso_out.ready) |=> (aso_out.valid && $stable(aso_out.data)
            && $stable(aso_out.startofpacket) && $stable(aso_out.endofpacket)));
`endif

endmodule

// File: tb/tb_reverse_base_stack.sv
// Bench for reverse_base_stack: cycle-exact vector table, reset abort sequence,
// then random packets checked against a queue-based reverse/truncate model.
module tb_reverse_base_stack;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic             clk;
    logic             rst_n;
    logic             ovf;
    logic [ADDR_W:0]  lvl;

    reverse_base_stack_if in_if ();
    reverse_base_stack_if out_if ();

    reverse_base_stack #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .csi_clock    (clk),
        .rsi_reset_n  (rst_n),
        .asi_in       (in_if),
        .aso_out      (out_if),
        .coe_overflow (ovf),
        .coe_level    (lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Table vectors: inputs for one cycle and the outputs expected before its edge.
    // expv = {in_ready, out_valid, out_data[7:0], sop, eop, level[2:0], overflow}
    typedef struct {
        logic        iv;
        logic [7:0]  id;
        logic        ie;
        logic        ordy;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic iv, logic [7:0] id, logic ie, logic ordy,
                                logic er, logic ev, logic [7:0] ed, logic es, logic ee,
                                logic [2:0] el, logic eo);
        vec_t v;
        v.iv   = iv;
        v.id   = id;
        v.ie   = ie;
        v.ordy = ordy;
        v.expv = {er, ev, ed, es, ee, el, eo};
        vecs.push_back(v);
    endfunction

    // Scoreboard: {data, sop, eop, level at the time of the beat}
    logic [12:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          ovf_seen = 0;
    logic        stall_q = 1'b0;
    logic [10:0] held_q = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_if.valid) chk("in_ready_in_drain", 32'(in_if.ready), 32'd0);
            if (stall_q) begin
                chk("hold", {20'd0, out_if.valid, out_if.data, out_if.startofpacket,
                    out_if.endofpacket}, {20'd0, 1'b1, held_q[9:0]});
            end
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", out_if.data);
                end else begin
                    chk("beat", {19'd0, out_if.data, out_if.startofpacket,
                        out_if.endofpacket, lvl}, {19'd0, exp_q.pop_front()});
                end
            end
            if (ovf) ovf_seen <= ovf_seen + 1;
        end
        stall_q <= out_if.valid && !out_if.ready;
        held_q  <= {1'b0, out_if.data, out_if.startofpacket, out_if.endofpacket};
    end

    task automatic send_beat(input logic [7:0] d, input logic e);
        int  n    = 0;
        bit  done = 1'b0;
        in_if.valid       = 1'b1;
        in_if.data        = d;
        in_if.endofpacket = e;
        while (!done) begin
            @(negedge clk);
            if (in_if.ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stuck required=accept");
                done = 1'b1;
            end
        end
        in_if.valid       = 1'b0;
        in_if.endofpacket = 1'b0;
    endtask

    // Reference: output is the first min(n, DEPTH) bases in reverse order.
    function automatic void model_packet(input logic [7:0] b[8], input int n);
        int k;
        k = (n > DEPTH) ? DEPTH : n;
        for (int i = k - 1; i >= 0; i--) begin
            exp_q.push_back({b[i], 1'(i == k - 1), 1'(i == 0), 3'(i + 1)});
        end
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%0d_left required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    int   exp_ovf = 0;
    bit   rand_on = 1'b0;

    initial begin
        logic [7:0] b[8];
        int         n;

        rst_n                = 1'b0;
        in_if.valid          = 1'b0;
        in_if.data           = 8'h00;
        in_if.endofpacket    = 1'b0;
        in_if.startofpacket  = 1'b0;
        out_if.ready         = 1'b1;

        @(negedge clk);
        chk("reset_state", {16'd0, in_if.ready, out_if.valid, out_if.data,
            out_if.startofpacket, out_if.endofpacket, lvl, ovf}, 32'd0);

        // Forward order T,G,C,A; free-flowing output.
        add(1, 8'h54, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(1, 8'h47, 0, 1,  1, 0, 8'h00, 0, 0, 3'd1, 0);
        add(1, 8'h43, 0, 1,  1, 0, 8'h00, 0, 0, 3'd2, 0);
        add(1, 8'h41, 1, 1,  1, 0, 8'h00, 0, 0, 3'd3, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h41, 1, 0, 3'd4, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h43, 0, 0, 3'd3, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h47, 0, 0, 3'd2, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h54, 0, 1, 3'd1, 0);
        add(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        // Same packet, output ready alternating; each beat held through a stall.
        add(1, 8'h54, 0, 0,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(1, 8'h47, 0, 0,  1, 0, 8'h00, 0, 0, 3'd1, 0);
        add(1, 8'h43, 0, 0,  1, 0, 8'h00, 0, 0, 3'd2, 0);
        add(1, 8'h41, 1, 0,  1, 0, 8'h00, 0, 0, 3'd3, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h41, 1, 0, 3'd4, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h41, 1, 0, 3'd4, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h43, 0, 0, 3'd3, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h43, 0, 0, 3'd3, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h47, 0, 0, 3'd2, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h47, 0, 0, 3'd2, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h54, 0, 1, 3'd1, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h54, 0, 1, 3'd1, 0);
        add(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        // Single-base packet.
        add(1, 8'h47, 1, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h47, 1, 1, 3'd1, 0);
        add(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        // Six beats into a four-deep stack: truncate, replay 4..1, drop 5 and 6.
        add(1, 8'h01, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(1, 8'h02, 0, 1,  1, 0, 8'h00, 0, 0, 3'd1, 0);
        add(1, 8'h03, 0, 1,  1, 0, 8'h00, 0, 0, 3'd2, 0);
        add(1, 8'h04, 0, 1,  1, 0, 8'h00, 0, 0, 3'd3, 0);
        add(1, 8'h05, 0, 1,  0, 1, 8'h04, 1, 0, 3'd4, 1);
        add(1, 8'h05, 0, 1,  0, 1, 8'h03, 0, 0, 3'd3, 0);
        add(1, 8'h05, 0, 1,  0, 1, 8'h02, 0, 0, 3'd2, 0);
        add(1, 8'h05, 0, 1,  0, 1, 8'h01, 0, 1, 3'd1, 0);
        add(1, 8'h05, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(1, 8'h06, 1, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(1, 8'h11, 1, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h11, 1, 1, 3'd1, 0);
        add(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0, 3'd0, 0);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_if.valid       = vecs[i].iv;
            in_if.data        = vecs[i].id;
            in_if.endofpacket = vecs[i].ie;
            out_if.ready      = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {16'd0, in_if.ready, out_if.valid, out_if.data,
                out_if.startofpacket, out_if.endofpacket, lvl, ovf}, {16'd0, vecs[i].expv});
            @(posedge clk);
            #1;
        end
        in_if.valid       = 1'b0;
        in_if.endofpacket = 1'b0;
        out_if.ready      = 1'b1;

        // Reset in the middle of a drain.
        send_beat(8'h54, 1'b0);
        send_beat(8'h47, 1'b0);
        send_beat(8'h43, 1'b0);
        send_beat(8'h41, 1'b1);
        @(negedge clk);
        chk("abort_beat0", {22'd0, out_if.valid, out_if.data, out_if.startofpacket},
            {22'd0, 1'b1, 8'h41, 1'b1});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_beat1", {22'd0, out_if.valid, out_if.data, out_if.startofpacket},
            {22'd0, 1'b1, 8'h43, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_reset", {16'd0, in_if.ready, out_if.valid, out_if.data,
            out_if.startofpacket, out_if.endofpacket, lvl, ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        b[0] = 8'h10;
        b[1] = 8'h20;
        b[2] = 8'h30;
        model_packet(b, 3);
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b1);
        wait_drain("abort_next_pkt");

        // Random packets with random gaps and random output backpressure.
        ovf_seen = 0;
        rand_on  = 1'b1;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    n = $urandom_range(1, 7);
                    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
                    model_packet(b, n);
                    if (n > DEPTH) exp_ovf++;
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send_beat(b[i], 1'(i == n - 1));
                    end
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_if.ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_if.ready = 1'b1;
        wait_drain("random_drain");
        chk("overflow_count", 32'(ovf_seen), 32'(exp_ovf));
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
